// File: rtl/csr_unit_pkg.sv
// Shared types for the flag/status register stage: the csr_t flag word,
// the branch condition encoding and the flag word width.
package csr_unit_pkg;

  localparam int CSR_W = 4;

  // Flag word as produced by the ALU, MSB first: {Sign, Zero, Carry, Overflow}
  typedef struct packed {
    logic s;
    logic z;
    logic c;
    logic o;
  } csr_t;

  // Branch condition codes evaluated against a csr_t
  typedef enum logic [2:0] {
    COND_AL = 3'd0,
    COND_EQ = 3'd1,
    COND_NE = 3'd2,
    COND_LT = 3'd3,
    COND_GE = 3'd4,
    COND_CS = 3'd5,
    COND_CC = 3'd6,
    COND_GT = 3'd7
  } cond_t;

endpackage

// File: rtl/csr_unit_shadow_stack.sv
// LIFO of saved flag words used across interrupt entry/return.
// Only the occupancy pointer is reset; entry contents are don't-care.
module csr_unit_shadow_stack
  import csr_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  csr_t                       push_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output csr_t                       top
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  csr_t          mem_r [DEPTH];
  logic [DW-1:0] depth_r;
  logic [DW-1:0] top_ptr_s;

  assign full      = (depth_r == DW'(DEPTH));
  assign empty     = (depth_r == {DW{1'b0}});
  assign depth     = depth_r;
  assign top_ptr_s = depth_r - {{(DW-1){1'b0}}, 1'b1};
  assign top       = mem_r[top_ptr_s[IW-1:0]];

  // Occupancy pointer: push and pop are never both requested by the caller
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_r <= {DW{1'b0}};
    end else if (push && !full) begin
      depth_r <= depth_r + {{(DW-1){1'b0}}, 1'b1};
    end else if (pop && !empty) begin
      depth_r <= top_ptr_s;
    end else begin
      depth_r <= depth_r;
    end
  end

  // Entry storage, written at the current pointer on push
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[depth_r[IW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Flag/status register stage after the ALU: commits flags, evaluates branch
// conditions and saves/restores flags across interrupts via a shadow stack.
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter bit FORWARD = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flags_we,
  input  logic [CSR_W-1:0]           csr_next,
  input  logic                       csr_wr_en,
  input  logic [CSR_W-1:0]           csr_wr_data,
  input  logic [2:0]                 cond,
  input  logic                       irq_enter,
  input  logic                       irq_ret,
  input  logic                       err_clr,
  output logic [CSR_W-1:0]           csr_q,
  output logic                       branch_taken,
  output logic [$clog2(DEPTH+1)-1:0] stack_depth,
  output logic                       stack_err
);

  csr_t csr_r;
  csr_t base_nxt_s;
  csr_t nxt_s;
  csr_t br_flags_s;
  csr_t top_s;
  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic err_set_s;
  logic err_r;

  csr_unit_shadow_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (base_nxt_s),
    .full      (full_s),
    .empty     (empty_s),
    .depth     (stack_depth),
    .top       (top_s)
  );

  // Stack control and error detection; simultaneous enter+ret does neither
  always_comb begin
    push_s    = irq_enter && !irq_ret && !full_s;
    pop_s     = irq_ret && !irq_enter && !empty_s;
    err_set_s = (irq_enter && irq_ret)
              || (irq_enter && !irq_ret && full_s)
              || (irq_ret && !irq_enter && empty_s);
  end

  // Next-CSR priority mux: pop > software write > ALU flags > hold
  always_comb begin
    if (csr_wr_en) begin
      base_nxt_s = csr_t'(csr_wr_data);
    end else if (flags_we) begin
      base_nxt_s = csr_t'(csr_next);
    end else begin
      base_nxt_s = csr_r;
    end
    if (pop_s) begin
      nxt_s = top_s;
    end else begin
      nxt_s = base_nxt_s;
    end
  end

  // Committed flag register and sticky stack error (set wins over clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      csr_r <= '0;
      err_r <= 1'b0;
    end else begin
      csr_r <= nxt_s;
      if (err_set_s) begin
        err_r <= 1'b1;
      end else if (err_clr) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign csr_q     = csr_r;
  assign stack_err = err_r;

  // Branch flag selection with optional same-cycle bypass of ALU flags
  always_comb begin
    if (FORWARD && flags_we && !csr_wr_en && !irq_ret) begin
      br_flags_s = csr_t'(csr_next);
    end else begin
      br_flags_s = csr_r;
    end
  end

  // Condition decoder
  always_comb begin
    case (cond_t'(cond))
      COND_AL: branch_taken = 1'b1;
      COND_EQ: branch_taken = br_flags_s.z;
      COND_NE: branch_taken = !br_flags_s.z;
      COND_LT: branch_taken = (br_flags_s.s != br_flags_s.o);
      COND_GE: branch_taken = (br_flags_s.s == br_flags_s.o);
      COND_CS: branch_taken = br_flags_s.c;
      COND_CC: branch_taken = !br_flags_s.c;
      COND_GT: branch_taken = !br_flags_s.z && (br_flags_s.s == br_flags_s.o);
      default: branch_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit (DEPTH=4), with a FORWARD=0
// instance sharing the same stimulus for the bypass comparison.
module tb_csr_unit;
  import csr_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flags_we;
  logic [3:0] csr_next;
  logic       csr_wr_en;
  logic [3:0] csr_wr_data;
  logic [2:0] cond;
  logic       irq_enter;
  logic       irq_ret;
  logic       err_clr;
  logic [3:0] csr_q;
  logic       branch_taken;
  logic [2:0] stack_depth;
  logic       stack_err;
  logic [3:0] csr_q_nf;
  logic       branch_taken_nf;
  logic [2:0] stack_depth_nf;
  logic       stack_err_nf;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  csr_unit #(.DEPTH(4), .FORWARD(1'b1)) dut (
    .clk(clk), .rst(rst), .flags_we(flags_we), .csr_next(csr_next),
    .csr_wr_en(csr_wr_en), .csr_wr_data(csr_wr_data), .cond(cond),
    .irq_enter(irq_enter), .irq_ret(irq_ret), .err_clr(err_clr),
    .csr_q(csr_q), .branch_taken(branch_taken),
    .stack_depth(stack_depth), .stack_err(stack_err)
  );

  csr_unit #(.DEPTH(4), .FORWARD(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .flags_we(flags_we), .csr_next(csr_next),
    .csr_wr_en(csr_wr_en), .csr_wr_data(csr_wr_data), .cond(cond),
    .irq_enter(irq_enter), .irq_ret(irq_ret), .err_clr(err_clr),
    .csr_q(csr_q_nf), .branch_taken(branch_taken_nf),
    .stack_depth(stack_depth_nf), .stack_err(stack_err_nf)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flags_we = 1'b0; csr_next = 4'h0; csr_wr_en = 1'b0; csr_wr_data = 4'h0;
    irq_enter = 1'b0; irq_ret = 1'b0; err_clr = 1'b0;
  endtask

  task automatic wr_csr(input logic [3:0] v);
    csr_wr_en = 1'b1; csr_wr_data = v;
    tick();
    idle();
  endtask

  // Condition table: {cond, flags, expected}
  typedef struct {
    logic [2:0] c;
    logic [3:0] f;
    logic       e;
  } cvec_t;

  cvec_t cvec [10] = '{
    '{3'd3, 4'b1000, 1'b1}, '{3'd4, 4'b1000, 1'b0}, '{3'd7, 4'b1000, 1'b0},
    '{3'd3, 4'b1001, 1'b0}, '{3'd4, 4'b1001, 1'b1}, '{3'd7, 4'b1001, 1'b1},
    '{3'd5, 4'b0110, 1'b1}, '{3'd6, 4'b0110, 1'b0}, '{3'd2, 4'b0110, 1'b0},
    '{3'd0, 4'b0110, 1'b1}
  };

  initial begin
    idle();
    cond = 3'd0;
    rst  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_csr",   8'(csr_q), 8'h00);
    chk("rst_depth", 8'(stack_depth), 8'h00);
    chk("rst_err",   8'(stack_err), 8'h00);

    // 1: commit Z, forwarded branch in the same cycle
    flags_we = 1'b1; csr_next = 4'b0100; cond = 3'd1;
    #1;
    chk("t1_csr_before", 8'(csr_q), 8'h00);
    chk("t1_eq_fwd",     8'(branch_taken), 8'h01);
    chk("t1_eq_nofwd",   8'(branch_taken_nf), 8'h00);
    tick();
    idle();
    #1;
    chk("t1_csr_after", 8'(csr_q), 8'h04);
    chk("t1_eq_commit", 8'(branch_taken), 8'h01);

    // 2: condition decoder over committed flags
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || i == 3 || i == 6) wr_csr(cvec[i].f);
      cond = cvec[i].c;
      #1;
      chk($sformatf("t2_cond%0d_f%0h", cvec[i].c, cvec[i].f), 8'(branch_taken), 8'(cvec[i].e));
    end

    // 3: fill the stack, overflow, then pop back in LIFO order
    for (int i = 1; i <= 4; i++) begin
      irq_enter = 1'b1; flags_we = 1'b1; csr_next = 4'(i);
      tick();
      idle();
    end
    chk("t3_full_depth", 8'(stack_depth), 8'h04);
    chk("t3_full_err",   8'(stack_err), 8'h00);
    chk("t3_full_csr",   8'(csr_q), 8'h04);
    irq_enter = 1'b1; flags_we = 1'b1; csr_next = 4'hF;
    tick();
    idle();
    chk("t3_ovf_depth", 8'(stack_depth), 8'h04);
    chk("t3_ovf_err",   8'(stack_err), 8'h01);
    chk("t3_ovf_csr",   8'(csr_q), 8'h0F);
    err_clr = 1'b1;
    tick();
    idle();
    chk("t3_clr_err", 8'(stack_err), 8'h00);
    for (int i = 4; i >= 1; i--) begin
      irq_ret = 1'b1;
      tick();
      idle();
      chk($sformatf("t3_pop%0d_csr", i), 8'(csr_q), 8'(i));
      chk($sformatf("t3_pop%0d_depth", i), 8'(stack_depth), 8'(i - 1));
    end
    chk("t3_pop_err", 8'(stack_err), 8'h00);

    // 4: push captures the completing ALU flags; pop beats flags_we
    irq_enter = 1'b1; flags_we = 1'b1; csr_next = 4'b0010;
    tick();
    idle();
    chk("t4_push_depth", 8'(stack_depth), 8'h01);
    chk("t4_push_csr",   8'(csr_q), 8'h02);
    wr_csr(4'h0);
    chk("t4_wr0_csr", 8'(csr_q), 8'h00);
    irq_ret = 1'b1; flags_we = 1'b1; csr_next = 4'b0100; cond = 3'd1;
    #1;
    chk("t4_ret_nobypass", 8'(branch_taken), 8'h00);
    tick();
    idle();
    chk("t4_pop_csr",   8'(csr_q), 8'h02);
    chk("t4_pop_depth", 8'(stack_depth), 8'h00);

    // 5: underflow, simultaneous pulses, set-wins-over-clear
    irq_ret = 1'b1; flags_we = 1'b1; csr_next = 4'b1001;
    tick();
    idle();
    chk("t5_unf_err",   8'(stack_err), 8'h01);
    chk("t5_unf_csr",   8'(csr_q), 8'h09);
    chk("t5_unf_depth", 8'(stack_depth), 8'h00);
    err_clr = 1'b1;
    tick();
    idle();
    chk("t5_clr_err", 8'(stack_err), 8'h00);
    irq_enter = 1'b1;
    tick();
    idle();
    chk("t5_push_depth", 8'(stack_depth), 8'h01);
    irq_enter = 1'b1; irq_ret = 1'b1;
    tick();
    idle();
    chk("t5_both_depth", 8'(stack_depth), 8'h01);
    chk("t5_both_err",   8'(stack_err), 8'h01);
    chk("t5_both_csr",   8'(csr_q), 8'h09);
    irq_enter = 1'b1; irq_ret = 1'b1; err_clr = 1'b1;
    tick();
    idle();
    chk("t5_setwins_err", 8'(stack_err), 8'h01);
    err_clr = 1'b1;
    tick();
    idle();
    chk("t5_clr2_err", 8'(stack_err), 8'h00);

    // 6: reset mid-sequence discards the stack
    irq_enter = 1'b1; flags_we = 1'b1; csr_next = 4'h6;
    tick();
    idle();
    chk("t6_depth2", 8'(stack_depth), 8'h02);
    irq_enter = 1'b1; irq_ret = 1'b1;
    tick();
    idle();
    chk("t6_err_pre", 8'(stack_err), 8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_depth", 8'(stack_depth), 8'h00);
    chk("t6_rst_csr",   8'(csr_q), 8'h00);
    chk("t6_rst_err",   8'(stack_err), 8'h00);
    irq_ret = 1'b1;
    tick();
    idle();
    chk("t6_unf_err",   8'(stack_err), 8'h01);
    chk("t6_unf_depth", 8'(stack_depth), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
